// File: rtl/tau_pkg.sv
// Shared definitions for the tau encoder/decoder/mac family.
// Holds the frame FSM state encoding and the default datapath width.
package tau_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        COLLECT = 2'd2
    } tau_state_t;

    localparam int TAU_BITWIDTH = 8;

endpackage

// File: rtl/tau_onehot_check.sv
// Combinational one-hot classifier for a tau beat: flags exactly-one-set and
// reports the index of the highest set bit (zero when no bit is set).
module tau_onehot_check
    import tau_pkg::*;
#(
    parameter int  BITWIDTH = TAU_BITWIDTH,
    localparam int PW       = (BITWIDTH > 1) ? $clog2(BITWIDTH) : 1
) (
    input  logic [BITWIDTH-1:0] vec,
    output logic                is_onehot,
    output logic [PW-1:0]       pos
);

    always_comb begin
        is_onehot = (vec != '0) && ((vec & (vec - BITWIDTH'(1))) == '0);
        pos       = '0;
        // Ascending scan so the highest set bit wins on malformed beats.
        for (int i = 0; i < BITWIDTH; i++) begin
            if (vec[i]) begin
                pos = PW'(i);
            end
        end
    end

endmodule

// File: rtl/tau_decoder.sv
// Decodes a start-delimited stream of descending one-hot beats into a binary value;
// result registered 1 cycle after the frame-ending idle cycle, held until out_ready, never stalls the encoder.
module tau_decoder
    import tau_pkg::*;
#(
    parameter int BITWIDTH = TAU_BITWIDTH,
    parameter int TIMEOUT  = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [BITWIDTH-1:0] count_by,
    input  logic                count_by_valid,
    input  logic                out_ready,
    output logic [BITWIDTH-1:0] n,
    output logic                n_valid,
    output logic                error,
    output logic                overrun
);

    localparam int         PW = (BITWIDTH > 1) ? $clog2(BITWIDTH) : 1;
    localparam logic [3:0] TO = 4'(TIMEOUT);

    tau_state_t          state_q, state_d;
    logic [BITWIDTH-1:0] acc_q, acc_d;
    logic [PW-1:0]       last_q, last_d;
    logic                ferr_q, ferr_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [BITWIDTH-1:0] n_q, n_d;
    logic                n_valid_q, n_valid_d;
    logic                error_q, error_d;
    logic                overrun_q, overrun_d;

    logic                beat_onehot;
    logic [PW-1:0]       beat_pos;
    logic                beat_bad;
    logic                fin;

    tau_onehot_check #(
        .BITWIDTH (BITWIDTH)
    ) u_onehot_check (
        .vec       (count_by),
        .is_onehot (beat_onehot),
        .pos       (beat_pos)
    );

    // Ordering only matters once a previous beat exists, i.e. in COLLECT.
    assign beat_bad = !beat_onehot || ((state_q == COLLECT) && (beat_pos >= last_q));

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        last_d    = last_q;
        ferr_d    = ferr_q;
        cnt_d     = cnt_q;
        n_d       = n_q;
        n_valid_d = n_valid_q;
        error_d   = error_q;
        overrun_d = overrun_q;
        fin       = 1'b0;

        if (start) begin
            fin     = (state_q != IDLE);
            state_d = WAIT;
            acc_d   = '0;
            last_d  = '0;
            ferr_d  = 1'b0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                WAIT, COLLECT: begin
                    if (count_by_valid) begin
                        acc_d   = acc_q | count_by;
                        ferr_d  = ferr_q | beat_bad;
                        last_d  = beat_pos;
                        state_d = COLLECT;
                    end else if (state_q == COLLECT) begin
                        fin     = 1'b1;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                        if (cnt_d == TO) begin
                            fin     = 1'b1;
                            state_d = IDLE;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        // acc_q/ferr_q are still clear while in WAIT, so a timeout yields n=0.
        if (fin) begin
            n_d       = acc_q;
            error_d   = ferr_q;
            n_valid_d = 1'b1;
            overrun_d = n_valid_q && !out_ready;
        end else if (n_valid_q && out_ready) begin
            n_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            last_q    <= '0;
            ferr_q    <= 1'b0;
            cnt_q     <= '0;
            n_q       <= '0;
            n_valid_q <= 1'b0;
            error_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            last_q    <= last_d;
            ferr_q    <= ferr_d;
            cnt_q     <= cnt_d;
            n_q       <= n_d;
            n_valid_q <= n_valid_d;
            error_q   <= error_d;
            overrun_q <= overrun_d;
        end
    end

    assign n       = n_q;
    assign n_valid = n_valid_q;
    assign error   = error_q;
    assign overrun = overrun_q;

endmodule

// File: tb/tb_tau_decoder.sv
// Directed scoreboard bench for tau_decoder (BITWIDTH=8, TIMEOUT=4).
module tb_tau_decoder;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] count_by;
    logic       count_by_valid;
    logic       out_ready;
    logic [7:0] n;
    logic       n_valid;
    logic       error;
    logic       overrun;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [7:0] n;
        logic       err;
        logic       ovr;
    } res_t;

    res_t sb_q[$];

    tau_decoder #(
        .BITWIDTH (8),
        .TIMEOUT  (4)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .count_by       (count_by),
        .count_by_valid (count_by_valid),
        .out_ready      (out_ready),
        .n              (n),
        .n_valid        (n_valid),
        .error          (error),
        .overrun        (overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, let the edge consume them, settle 1 time unit.
    task automatic cyc(input logic s, input logic [7:0] cb, input logic v);
        reset          = 1'b0;
        start          = s;
        count_by       = cb;
        count_by_valid = v;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic s, input logic [7:0] cb, input logic v);
        reset          = 1'b1;
        start          = s;
        count_by       = cb;
        count_by_valid = v;
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [7:0] en, input logic ee, input logic eo);
        res_t r;
        r.n   = en;
        r.err = ee;
        r.ovr = eo;
        sb_q.push_back(r);
    endtask

    task automatic expect_result(input string tag);
        res_t e;
        int   w;
        w = 0;
        while (n_valid !== 1'b1 && w < 6) begin
            cyc(1'b0, 8'h00, 1'b0);
            w++;
        end
        chk({tag, "_latency"}, w, 0);
        chk({tag, "_n_valid"}, n_valid, 1);
        chk({tag, "_sb_depth"}, sb_q.size(), 1);
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk({tag, "_n"}, n, e.n);
            chk({tag, "_error"}, error, e.err);
            chk({tag, "_overrun"}, overrun, e.ovr);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        out_ready = 1'b1;
        do_reset(1'b0, 8'h00, 1'b0);
        do_reset(1'b0, 8'h00, 1'b0);
        chk("rst_n", n, 0);
        chk("rst_n_valid", n_valid, 0);
        chk("rst_error", error, 0);
        chk("rst_overrun", overrun, 0);

        // Normal frame: 0x08, 0x02, 0x01 -> 0x0B
        cyc(1'b1, 8'h00, 1'b0);
        cyc(1'b0, 8'h00, 1'b0);
        cyc(1'b0, 8'h08, 1'b1);
        cyc(1'b0, 8'h02, 1'b1);
        cyc(1'b0, 8'h01, 1'b1);
        chk("normal_pre_valid", n_valid, 0);
        push_exp(8'h0B, 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 1'b0);
        expect_result("normal");
        cyc(1'b0, 8'h00, 1'b0);
        chk("normal_drop", n_valid, 0);

        // Zero value via timeout
        cyc(1'b1, 8'h00, 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b0, 8'h00, 1'b0);
        chk("zero_pre_timeout", n_valid, 0);
        push_exp(8'h00, 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 1'b0);
        expect_result("zero");
        cyc(1'b0, 8'h00, 1'b0);

        // Back-to-back frames
        cyc(1'b1, 8'h00, 1'b0);
        cyc(1'b0, 8'h80, 1'b1);
        cyc(1'b0, 8'h40, 1'b1);
        push_exp(8'hC0, 1'b0, 1'b0);
        cyc(1'b1, 8'h00, 1'b0);
        expect_result("b2b_first");
        cyc(1'b0, 8'h20, 1'b1);
        chk("b2b_accept_drop", n_valid, 0);
        push_exp(8'h20, 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 1'b0);
        expect_result("b2b_second");

        // start+beat together: beat dropped; start in WAIT emits zero
        cyc(1'b1, 8'h01, 1'b1);
        push_exp(8'h00, 1'b0, 1'b0);
        cyc(1'b1, 8'h00, 1'b0);
        expect_result("start_prio");
        push_exp(8'h00, 1'b0, 1'b0);
        cyc(1'b1, 8'h00, 1'b0);
        expect_result("fin_while_accept");
        cyc(1'b0, 8'h04, 1'b1);
        push_exp(8'h04, 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 1'b0);
        expect_result("after_prio");
        cyc(1'b0, 8'h00, 1'b0);

        // Malformed: non-one-hot beat
        cyc(1'b1, 8'h00, 1'b0);
        cyc(1'b0, 8'h03, 1'b1);
        push_exp(8'h03, 1'b1, 1'b0);
        cyc(1'b0, 8'h00, 1'b0);
        expect_result("bad_onehot");
        cyc(1'b0, 8'h00, 1'b0);

        // Malformed: ascending order
        cyc(1'b1, 8'h00, 1'b0);
        cyc(1'b0, 8'h02, 1'b1);
        cyc(1'b0, 8'h04, 1'b1);
        push_exp(8'h06, 1'b1, 1'b0);
        cyc(1'b0, 8'h00, 1'b0);
        expect_result("bad_order");
        cyc(1'b0, 8'h00, 1'b0);

        // Backpressure and overrun
        out_ready = 1'b0;
        cyc(1'b1, 8'h00, 1'b0);
        cyc(1'b0, 8'h04, 1'b1);
        cyc(1'b0, 8'h01, 1'b1);
        push_exp(8'h05, 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 1'b0);
        expect_result("bp_first");
        cyc(1'b1, 8'h00, 1'b0);
        cyc(1'b0, 8'h08, 1'b1);
        cyc(1'b0, 8'h01, 1'b1);
        chk("bp_hold_n", n, 8'h05);
        push_exp(8'h09, 1'b0, 1'b1);
        cyc(1'b0, 8'h00, 1'b0);
        expect_result("bp_overrun");
        cyc(1'b0, 8'h00, 1'b0);
        cyc(1'b0, 8'h00, 1'b0);
        chk("bp_stable_n", n, 8'h09);
        chk("bp_stable_ovr", overrun, 1);
        chk("bp_stable_vld", n_valid, 1);
        out_ready = 1'b1;
        cyc(1'b0, 8'h00, 1'b0);
        chk("bp_release_drop", n_valid, 0);

        // Reset mid-frame with a held result pending
        out_ready = 1'b0;
        cyc(1'b1, 8'h00, 1'b0);
        cyc(1'b0, 8'h02, 1'b1);
        push_exp(8'h02, 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 1'b0);
        expect_result("pre_reset");
        cyc(1'b1, 8'h00, 1'b0);
        cyc(1'b0, 8'h10, 1'b1);
        do_reset(1'b1, 8'h20, 1'b1);
        chk("midrst_n", n, 0);
        chk("midrst_n_valid", n_valid, 0);
        chk("midrst_error", error, 0);
        chk("midrst_overrun", overrun, 0);
        out_ready = 1'b1;
        cyc(1'b0, 8'h20, 1'b1);
        cyc(1'b0, 8'h40, 1'b1);
        for (int i = 0; i < 6; i++) begin
            cyc(1'b0, 8'h00, 1'b0);
            chk("idle_ignore", n_valid, 0);
        end
        cyc(1'b1, 8'h00, 1'b0);
        cyc(1'b0, 8'h01, 1'b1);
        push_exp(8'h01, 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 1'b0);
        expect_result("post_reset");
        cyc(1'b0, 8'h00, 1'b0);

        chk("sb_empty", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tau_decoder.md
TAU_DECODER -- requirements
Module: tau_decoder

Interface
REQ-001 Parameter BITWIDTH, default 8: width of the one-hot input and of the binary output.
REQ-002 Parameter TIMEOUT, default 4: idle cycles after start with no beat before a zero result is emitted; legal range 2..15.
REQ-003 clk  input  1  sole clock; all state updates on posedge clk.
REQ-004 reset  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  frame-begin pulse, same meaning as the encoder's start.
REQ-006 count_by  input  BITWIDTH  tau-encoded one-hot beat.
REQ-007 count_by_valid  input  1  count_by carries a beat this cycle.
REQ-008 out_ready  input  1  consumer accepts the result this cycle.
REQ-009 n  output  BITWIDTH  decoded binary value.
REQ-010 n_valid  output  1  n, error and overrun are valid; held until accepted.
REQ-011 error  output  1  the frame contained a malformed beat.
REQ-012 overrun  output  1  an unaccepted result was overwritten by this one.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE (no frame), WAIT (frame open, no beat yet), COLLECT (at least one beat received).
REQ-014 In IDLE, count_by_valid beats SHALL be ignored.
REQ-015 start in any state SHALL clear the accumulator, the last-position register, the error flag and the timeout counter, and SHALL enter WAIT next cycle.
REQ-016 If start arrives in WAIT or COLLECT, the open frame SHALL first be finalized with its current accumulator (zero if in WAIT).
REQ-017 In WAIT or COLLECT, a valid beat SHALL OR count_by into the accumulator and enter or stay in COLLECT.
REQ-018 A beat SHALL set the frame error flag if count_by is not exactly one-hot.
REQ-019 A beat SHALL also set the frame error flag if its bit position is not strictly below the previous beat's position in the same frame.
REQ-020 Malformed beats SHALL still be ORed into the accumulator.
REQ-021 In COLLECT, the first cycle with count_by_valid=0 SHALL finalize the frame and return the FSM to IDLE.
REQ-022 In WAIT, a counter SHALL count cycles with count_by_valid=0; on reaching TIMEOUT it SHALL finalize with n=0 and return to IDLE.
REQ-023 Finalize in cycle c SHALL load the output register, and n, error and n_valid SHALL show the result from cycle c+1.
REQ-024 n_valid SHALL stay high, with n, error and overrun stable, until a cycle with out_ready=1, and SHALL drop the next cycle unless a new finalize occurs.
REQ-025 If finalize coincides with n_valid=1 and out_ready=0, the new result SHALL replace the old one and overrun SHALL be 1 with it; otherwise overrun SHALL be 0.
REQ-026 If finalize coincides with out_ready=1 and n_valid=1, the new result SHALL load without overrun.
REQ-027 If a start and a valid beat occur in the same cycle, start SHALL take priority and the beat SHALL be ignored.
REQ-028 Decode latency SHALL be 1 cycle after the frame-ending idle cycle; there is no backpressure toward the encoder.

Reset
REQ-029 reset SHALL put the FSM in IDLE; clear accumulator, last position, counter and flags; and drive n=0, n_valid=0, error=0, overrun=0 the following cycle.
REQ-030 reset SHALL override start, beats and out_ready in the same cycle.
REQ-031 A frame in progress at reset SHALL be discarded with no result emitted.

Structure
REQ-032 A shared package tau_pkg SHALL hold the FSM state enum (IDLE, WAIT, COLLECT) and the default BITWIDTH constant; tau_encoder/tau_mac users import the same package.
REQ-033 One sub-module, tau_onehot_check, SHALL be combinational, with outputs is_onehot and pos, where pos is the binary index of the set bit.
REQ-034 All other logic SHALL be in tau_decoder.

Verification
REQ-035 Scenario, normal frame: start; one idle cycle; beats 0x08, 0x02, 0x01; one idle cycle -> n=0x0B, error=0, n_valid one cycle after the idle cycle.
REQ-036 Scenario, zero value: start followed by 4 idle cycles -> n=0x00, error=0.
REQ-037 Scenario, back-to-back frames: start, beats 0x80, 0x40, then start with no gap -> first frame n=0xC0; second frame collected independently.
REQ-038 Scenario, malformed beats: beats 0x03 -> error=1. Separate frame with beats 0x02 then 0x04 -> n=0x06, error=1.
REQ-039 Scenario, backpressure: out_ready=0 across two frames (0x05 then 0x09) -> n=0x09, overrun=1; raising out_ready drops n_valid the next cycle.
REQ-040 Scenario, reset mid-frame: reset after beat 0x10 -> all outputs 0 the next cycle; FSM in IDLE; later beats ignored until start.
